// File: rtl/classifier_vector_loader.sv
// -----------------------------------------------------------------------------
// classifier_vector_loader
//
// Streams feature values in one per beat and packs NUM_A of them into the flat
// input bus of a combinational classifier. Once a complete vector is loaded,
// the bus is held for SETTLE cycles so the classifier output can settle. The
// class is then registered and offered on a valid/ready output port.
// Loading, settling and output never overlap, so one vector is in flight at
// a time.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   s_valid    feature beat valid
//   s_ready    loader can accept a beat (only in the LOAD state)
//   s_data     unsigned feature value, WIDTH_A bits
//   s_last     marks the final beat of a vector
//   cls_inp    registered feature bus to the classifier, slot 0 in the LSBs
//   cls_out    classifier result, combinational in cls_inp
//   m_valid    class result valid
//   m_ready    downstream accepts the result
//   m_class    registered class
//   m_count    number of results delivered, wraps 0xFFFF -> 0
//   err_frame  one-cycle pulse: framing error, the partial vector was dropped
// -----------------------------------------------------------------------------
module classifier_vector_loader #(
  parameter int NUM_A    = 4,
  parameter int WIDTH_A  = 4,
  parameter int OUTWIDTH = 2,
  parameter int SETTLE   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [WIDTH_A-1:0]         s_data,
  input  logic                       s_last,
  output logic [NUM_A*WIDTH_A-1:0]   cls_inp,
  input  logic [OUTWIDTH-1:0]        cls_out,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [OUTWIDTH-1:0]        m_class,
  output logic [15:0]                m_count,
  output logic                       err_frame
);

  localparam int VEC_W = NUM_A * WIDTH_A;
  localparam int IDX_W = (NUM_A  > 1) ? $clog2(NUM_A)  : 1;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_A - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_OUTPUT = 2'd2
  } state_t;

  state_t                state_q,     state_d;
  logic [IDX_W-1:0]      idx_q,       idx_d;
  logic [CNT_W-1:0]      cnt_q,       cnt_d;
  logic [VEC_W-1:0]      cls_inp_q,   cls_inp_d;
  logic [OUTWIDTH-1:0]   m_class_q,   m_class_d;
  logic                  m_valid_q,   m_valid_d;
  logic [15:0]           m_count_q,   m_count_d;
  logic                  err_frame_q, err_frame_d;

  logic s_ready_int;
  logic beat;
  logic last_slot;
  logic frame_end;
  logic frame_err;
  logic settle_done;
  logic m_fire;

  // Handshake qualifiers shared by the next-state and datapath logic.
  assign beat        = s_valid & s_ready_int;
  assign last_slot   = (idx_q == LAST_IDX);
  // A vector is well framed only when s_last coincides with the final slot;
  // any disagreement between the two is a framing error.
  assign frame_end   = beat & last_slot & s_last;
  assign frame_err   = beat & (last_slot ^ s_last);
  assign settle_done = (cnt_q == LAST_CNT);
  assign m_fire      = m_valid_q & m_ready;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      idx_q       <= '0;
      cnt_q       <= '0;
      cls_inp_q   <= '0;
      m_class_q   <= '0;
      m_valid_q   <= 1'b0;
      m_count_q   <= '0;
      err_frame_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      cls_inp_q   <= cls_inp_d;
      m_class_q   <= m_class_d;
      m_valid_q   <= m_valid_d;
      m_count_q   <= m_count_d;
      err_frame_q <= err_frame_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_LOAD:   if (frame_end)   state_d = ST_SETTLE;
      ST_SETTLE: if (settle_done) state_d = ST_OUTPUT;
      ST_OUTPUT: if (m_fire)      state_d = ST_LOAD;
      default:                    state_d = ST_LOAD;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    cls_inp_d   = cls_inp_q;
    m_class_d   = m_class_q;
    m_valid_d   = m_valid_q;
    m_count_d   = m_count_q;
    err_frame_d = 1'b0;

    unique case (state_q)
      ST_LOAD: begin
        cnt_d = '0;
        if (beat) begin
          // Every accepted beat lands in its slot, even one that turns out to
          // be badly framed; stale slots are simply overwritten later.
          for (int i = 0; i < NUM_A; i++) begin
            if (idx_q == IDX_W'(i)) begin
              cls_inp_d[i*WIDTH_A +: WIDTH_A] = s_data;
            end
          end
          if (frame_err) begin
            idx_d       = '0;
            err_frame_d = 1'b1;
          end else if (!last_slot) begin
            idx_d = idx_q + IDX_W'(1);
          end else begin
            idx_d = '0;
          end
        end
      end

      ST_SETTLE: begin
        // cls_inp has been stable for SETTLE edges when this fires, so the
        // classifier output is safe to capture.
        if (settle_done) begin
          m_class_d = cls_out;
          m_valid_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_OUTPUT: begin
        if (m_fire) begin
          m_valid_d = 1'b0;
          m_count_d = m_count_q + 16'd1;
          idx_d     = '0;
        end
      end

      default: begin
        idx_d = '0;
        cnt_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    s_ready_int = (state_q == ST_LOAD);
  end

  assign s_ready   = s_ready_int;
  assign cls_inp   = cls_inp_q;
  assign m_valid   = m_valid_q;
  assign m_class   = m_class_q;
  assign m_count   = m_count_q;
  assign err_frame = err_frame_q;

endmodule

// File: tb/tb_classifier_vector_loader.sv
// -----------------------------------------------------------------------------
// Testbench for classifier_vector_loader (NUM_A=4, WIDTH_A=4, OUTWIDTH=2,
// SETTLE=2). A small weighted-sum function stands in for the classifier.
// -----------------------------------------------------------------------------
module tb_classifier_vector_loader;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [3:0]  s_data;
  logic        s_last;
  logic [15:0] cls_inp;
  logic [1:0]  cls_out;
  logic        m_valid;
  logic        m_ready;
  logic [1:0]  m_class;
  logic [15:0] m_count;
  logic        err_frame;

  int checks;
  int errors;

  classifier_vector_loader #(
    .NUM_A(4), .WIDTH_A(4), .OUTWIDTH(2), .SETTLE(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .cls_inp(cls_inp), .cls_out(cls_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_class(m_class),
    .m_count(m_count), .err_frame(err_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in classifier: weighted sum of the four features, modulo 4.
  function automatic logic [1:0] cls_model(input logic [15:0] v);
    int s;
    s = int'(v[3:0]) + 2 * int'(v[7:4]) + 3 * int'(v[11:8]) + int'(v[15:12]);
    return s[1:0];
  endfunction

  assign cls_out = cls_model(cls_inp);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at a falling edge, then step to the next one.
  task automatic cyc(input logic sv, input logic [3:0] d, input logic l, input logic mr);
    s_valid = sv;
    s_data  = d;
    s_last  = l;
    m_ready = mr;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        sv;
    logic [3:0]  d;
    logic        l;
    logic        mr;
    logic        e_srdy;
    logic        e_mv;
    logic        e_err;
    logic [15:0] e_inp;
    logic [1:0]  e_cls;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t        tbl [24];
  logic [15:0] vecs [150];
  int          n_out;
  logic        err_seen;

  initial begin
    checks   = 0;
    errors   = 0;
    n_out    = 0;
    err_seen = 1'b0;
    rst_n    = 1'b0;
    s_valid  = 1'b0;
    s_data   = 4'h0;
    s_last   = 1'b0;
    m_ready  = 1'b0;

    //            sv  d     l  mr   srdy mv err inp       cls   cnt
    // Clean vector 5,3,1,0 -> 0x0135, class 2, m_valid two cycles after last beat
    tbl[0]  = '{1'b1, 4'h5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0005, 2'd0, 16'd0};
    tbl[1]  = '{1'b1, 4'h3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0035, 2'd0, 16'd0};
    tbl[2]  = '{1'b1, 4'h1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0135, 2'd0, 16'd0};
    tbl[3]  = '{1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0135, 2'd0, 16'd0};
    tbl[4]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0135, 2'd0, 16'd0};
    tbl[5]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0135, 2'd2, 16'd0};
    tbl[6]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0135, 2'd2, 16'd1};
    // s_last on the 2nd beat -> framing error, then clean 2,4,6,9 -> class 1
    tbl[7]  = '{1'b1, 4'h7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0137, 2'd2, 16'd1};
    tbl[8]  = '{1'b1, 4'h9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0197, 2'd2, 16'd1};
    tbl[9]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0197, 2'd2, 16'd1};
    tbl[10] = '{1'b1, 4'h2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0192, 2'd2, 16'd1};
    tbl[11] = '{1'b1, 4'h4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0142, 2'd2, 16'd1};
    tbl[12] = '{1'b1, 4'h6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0642, 2'd2, 16'd1};
    tbl[13] = '{1'b1, 4'h9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h9642, 2'd2, 16'd1};
    // s_valid while not ready must be ignored
    tbl[14] = '{1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h9642, 2'd2, 16'd1};
    tbl[15] = '{1'b1, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h9642, 2'd1, 16'd1};
    tbl[16] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h9642, 2'd1, 16'd2};
    // 4th beat without s_last -> framing error, class never sampled, idx back to 0
    tbl[17] = '{1'b1, 4'h1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h9641, 2'd1, 16'd2};
    tbl[18] = '{1'b1, 4'h1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h9611, 2'd1, 16'd2};
    tbl[19] = '{1'b1, 4'h1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h9111, 2'd1, 16'd2};
    tbl[20] = '{1'b1, 4'h1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h1111, 2'd1, 16'd2};
    tbl[21] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1111, 2'd1, 16'd2};
    tbl[22] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1111, 2'd1, 16'd2};
    tbl[23] = '{1'b1, 4'h3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1113, 2'd1, 16'd2};

    // ---------------- reset state ----------------
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_s_ready",  32'(s_ready),   32'd1);
    check("rst_m_valid",  32'(m_valid),   32'd0);
    check("rst_cls_inp",  32'(cls_inp),   32'd0);
    check("rst_m_class",  32'(m_class),   32'd0);
    check("rst_m_count",  32'(m_count),   32'd0);
    check("rst_err",      32'(err_frame), 32'd0);
    rst_n = 1'b1;

    // ---------------- table-driven sequence ----------------
    for (int i = 0; i < 24; i++) begin
      cyc(tbl[i].sv, tbl[i].d, tbl[i].l, tbl[i].mr);
      check($sformatf("row%0d_s_ready", i), 32'(s_ready),   32'(tbl[i].e_srdy));
      check($sformatf("row%0d_m_valid", i), 32'(m_valid),   32'(tbl[i].e_mv));
      check($sformatf("row%0d_err", i),     32'(err_frame), 32'(tbl[i].e_err));
      check($sformatf("row%0d_cls_inp", i), 32'(cls_inp),   32'(tbl[i].e_inp));
      check($sformatf("row%0d_m_class", i), 32'(m_class),   32'(tbl[i].e_cls));
      check($sformatf("row%0d_m_count", i), 32'(m_count),   32'(tbl[i].e_cnt));
    end

    // ---------------- backpressure: m_ready low for 10 cycles ----------------
    do_reset();
    cyc(1'b1, 4'hC, 1'b0, 1'b0);
    cyc(1'b1, 4'h7, 1'b0, 1'b0);
    cyc(1'b1, 4'hA, 1'b0, 1'b0);
    cyc(1'b1, 4'h2, 1'b1, 1'b0);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    check("bp_mv_early", 32'(m_valid), 32'd0);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    check("bp_mv_latency", 32'(m_valid), 32'd1);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, 4'h5, 1'b1, 1'b0);
      check($sformatf("bp%0d_m_valid", k), 32'(m_valid), 32'd1);
      check($sformatf("bp%0d_m_class", k), 32'(m_class), 32'(cls_model(16'h2A7C)));
      check($sformatf("bp%0d_cls_inp", k), 32'(cls_inp), 32'h2A7C);
      check($sformatf("bp%0d_s_ready", k), 32'(s_ready), 32'd0);
      check($sformatf("bp%0d_m_count", k), 32'(m_count), 32'd0);
    end
    cyc(1'b0, 4'h0, 1'b0, 1'b1);
    check("bp_release_mv",    32'(m_valid), 32'd0);
    check("bp_release_count", 32'(m_count), 32'd1);
    check("bp_release_srdy",  32'(s_ready), 32'd1);
    cyc(1'b0, 4'h0, 1'b0, 1'b1);
    check("bp_count_once", 32'(m_count), 32'd1);

    // ---------------- reset during SETTLE ----------------
    cyc(1'b1, 4'h5, 1'b0, 1'b1);
    cyc(1'b1, 4'h3, 1'b0, 1'b1);
    cyc(1'b1, 4'h1, 1'b0, 1'b1);
    cyc(1'b1, 4'h0, 1'b1, 1'b1);
    cyc(1'b0, 4'h0, 1'b0, 1'b1);
    check("sr_in_settle", 32'(s_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("sr_m_valid", 32'(m_valid), 32'd0);
    check("sr_cls_inp", 32'(cls_inp), 32'd0);
    check("sr_m_count", 32'(m_count), 32'd0);
    check("sr_s_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 4'h0, 1'b0, 1'b1);
    check("sr_post_s_ready", 32'(s_ready), 32'd1);
    check("sr_post_m_valid", 32'(m_valid), 32'd0);
    cyc(1'b0, 4'h0, 1'b0, 1'b1);
    check("sr_no_late_valid", 32'(m_valid), 32'd0);

    // ---------------- 150-vector replay with random gaps ----------------
    begin
      logic [31:0] x;
      x = 32'h1234_5678;
      for (int i = 0; i < 150; i++) begin
        x = x * 32'd1103515245 + 32'd12345;
        vecs[i] = x[31:16];
      end
    end
    do_reset();
    fork
      begin : drv
        int j;
        int i;
        int c;
        j = 0;
        i = 0;
        c = 0;
        while (i < 150 && c < 20000) begin
          s_valid = ($urandom_range(0, 3) != 0);
          s_data  = vecs[i][j*4 +: 4];
          s_last  = (j == 3);
          if (s_valid && s_ready) begin
            if (j == 3) begin
              j = 0;
              i++;
            end else begin
              j++;
            end
          end
          @(negedge clk);
          c++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
      end
      begin : mon
        int c;
        c = 0;
        while (n_out < 150 && c < 20000) begin
          m_ready = ($urandom_range(0, 2) != 0);
          if (err_frame) err_seen = 1'b1;
          if (m_valid && m_ready) begin
            check($sformatf("replay%0d_class", n_out), 32'(m_class), 32'(cls_model(vecs[n_out])));
            check($sformatf("replay%0d_inp", n_out),   32'(cls_inp), 32'(vecs[n_out]));
            n_out++;
          end
          @(negedge clk);
          c++;
        end
        m_ready = 1'b0;
      end
    join
    check("replay_results", 32'(n_out),    32'd150);
    check("replay_m_count", 32'(m_count),  32'd150);
    check("replay_no_err",  32'(err_seen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
